// File: rtl/capture_pkg.sv
// Shared definitions for the threshold loader: load_reg field map and controller states.
package capture_pkg;

    localparam int LD_BIT  = 31;
    localparam int BC_BIT  = 30;
    localparam int CLR_BIT = 29;
    localparam int CH_LSB  = 16;
    localparam int THR_LSB = 0;
    localparam int CH_FW   = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SYNC,
        WRITE,
        SWEEP,
        TAIL
    } state_t;

    function automatic logic ch_in_range(input logic [CH_FW-1:0] ch, input int nch);
        return int'(ch) < nch;
    endfunction

endpackage

// File: rtl/capture_thresh_loader_if.sv
// Command register, frame sync and threshold-RAM write port of the threshold loader.
interface capture_thresh_loader_if #(
    parameter int CH_W  = 8,
    parameter int THR_W = 16
);
    logic [31:0]      load_reg;
    logic             sync_in;
    logic             thr_we;
    logic [CH_W-1:0]  thr_addr;
    logic [THR_W-1:0] thr_data;
    logic             capture_hold;
    logic             busy;
    logic [15:0]      load_count;
    logic             err_overrun;
    logic             err_range;

    modport master (
        input  load_reg, sync_in,
        output thr_we, thr_addr, thr_data, capture_hold, busy,
        output load_count, err_overrun, err_range
    );

    modport slave (
        output load_reg, sync_in,
        input  thr_we, thr_addr, thr_data, capture_hold, busy,
        input  load_count, err_overrun, err_range
    );
endinterface

// File: rtl/capture_edge_det.sv
// Rising-edge detector: registered previous value, combinational edge so the
// command can be acted on in the same cycle it is seen.
module capture_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= din;
    end

    assign rise = din & ~prev;
endmodule

// File: rtl/capture_thresh_loader.sv
// Sequences single-channel or broadcast threshold writes into the threshold RAM,
// optionally aligned to frame sync, holding capture off while the table changes.
module capture_thresh_loader
    import capture_pkg::*;
#(
    parameter int NCH        = 256,
    parameter int CH_W       = 8,
    parameter int THR_W      = 16,
    parameter int SYNC_ALIGN = 1,
    parameter int HOLD_TAIL  = 2   // must be >= 1
) (
    input  logic user_clk,
    input  logic user_rst_n,
    capture_thresh_loader_if.master bus
);
    localparam int TAIL_W = (HOLD_TAIL > 1) ? $clog2(HOLD_TAIL) : 1;
    localparam logic [CH_W-1:0]   LAST_ADDR = CH_W'(NCH - 1);
    localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(HOLD_TAIL - 1);

    state_t             state;
    logic               load_edge;
    logic               clr_err;
    logic               bc_field;
    logic [CH_FW-1:0]   ch_field;
    logic [THR_W-1:0]   thr_field;
    logic               range_bad;
    logic               accept;
    logic               start;
    logic               unused_bits;

    logic               lat_bc;
    logic [CH_W-1:0]    lat_ch;
    logic [THR_W-1:0]   lat_thr;
    logic               cmd_bc;
    logic [CH_W-1:0]    cmd_ch;
    logic [THR_W-1:0]   cmd_thr;
    logic [TAIL_W-1:0]  tail_cnt;

    logic               we;
    logic [CH_W-1:0]    addr;
    logic [THR_W-1:0]   data;
    logic               hold;
    logic               busy;
    logic [15:0]        count;
    logic               ovr;
    logic               rng;

    capture_edge_det u_load_edge (
        .clk   (user_clk),
        .rst_n (user_rst_n),
        .din   (bus.load_reg[LD_BIT]),
        .rise  (load_edge)
    );

    assign clr_err     = bus.load_reg[CLR_BIT];
    assign bc_field    = bus.load_reg[BC_BIT];
    assign ch_field    = bus.load_reg[CH_LSB +: CH_FW];
    assign thr_field   = bus.load_reg[THR_LSB +: THR_W];
    assign unused_bits = ^bus.load_reg[28:24];

    assign range_bad = !bc_field && !ch_in_range(ch_field, NCH);
    assign accept    = load_edge && (state == IDLE) && !range_bad;
    // Writes begin straight from the register when unaligned, else from the latch at sync.
    assign start     = (accept && SYNC_ALIGN == 0) || (state == WAIT_SYNC && bus.sync_in);

    always_comb begin
        cmd_bc  = lat_bc;
        cmd_ch  = lat_ch;
        cmd_thr = lat_thr;
        if (state == IDLE) begin
            cmd_bc  = bc_field;
            cmd_ch  = CH_W'(ch_field);
            cmd_thr = thr_field;
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state    <= IDLE;
            lat_bc   <= 1'b0;
            lat_ch   <= '0;
            lat_thr  <= '0;
            tail_cnt <= '0;
            we       <= 1'b0;
            addr     <= '0;
            data     <= '0;
            hold     <= 1'b0;
            busy     <= 1'b0;
            count    <= '0;
            ovr      <= 1'b0;
            rng      <= 1'b0;
        end else begin
            // Clear first so a same-cycle error set takes priority.
            if (clr_err) begin
                ovr <= 1'b0;
                rng <= 1'b0;
            end
            if (load_edge && state != IDLE)             ovr <= 1'b1;
            if (load_edge && state == IDLE && range_bad) rng <= 1'b1;

            if (accept) begin
                lat_bc  <= bc_field;
                lat_ch  <= CH_W'(ch_field);
                lat_thr <= thr_field;
                busy    <= 1'b1;
            end

            if (start) begin
                state <= cmd_bc ? SWEEP : WRITE;
                we    <= 1'b1;
                addr  <= cmd_bc ? '0 : cmd_ch;
                data  <= cmd_thr;
                hold  <= 1'b1;
                busy  <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (accept) state <= WAIT_SYNC;
                    WRITE, SWEEP: begin
                        if (state == WRITE || addr == LAST_ADDR) begin
                            we       <= 1'b0;
                            tail_cnt <= '0;
                            state    <= TAIL;
                        end else begin
                            addr <= addr + CH_W'(1);
                        end
                    end
                    TAIL: begin
                        if (tail_cnt == TAIL_LAST) begin
                            state <= IDLE;
                            hold  <= 1'b0;
                            busy  <= 1'b0;
                            count <= count + 16'd1;
                        end else begin
                            tail_cnt <= tail_cnt + TAIL_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.thr_we       = we;
    assign bus.thr_addr     = addr;
    assign bus.thr_data     = data;
    assign bus.capture_hold = hold;
    assign bus.busy         = busy;
    assign bus.load_count   = count;
    assign bus.err_overrun  = ovr;
    assign bus.err_range    = rng;
endmodule

// File: tb/tb_capture_thresh_loader.sv
// Two loader configurations driven by one shared command stream; each has its own
// window-based reference model, expected-write queue and monitor.
module tb_capture_thresh_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] load_reg = '0;
    logic        sync_in = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        hold;
        logic [15:0] lc;
        logic        eo;
        logic        er;
    } st_t;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int NCH = (g == 0) ? 200 : 256;
        localparam int SA  = (g == 0) ? 0 : 1;
        localparam int HT  = (g == 0) ? 2 : 3;

        capture_thresh_loader_if #(.CH_W(8), .THR_W(16)) bus ();
        assign bus.load_reg = load_reg;
        assign bus.sync_in  = sync_in;

        capture_thresh_loader #(
            .NCH(NCH), .CH_W(8), .THR_W(16), .SYNC_ALIGN(SA), .HOLD_TAIL(HT)
        ) dut (
            .user_clk   (clk),
            .user_rst_n (rst_n),
            .bus        (bus)
        );

        wr_t         wq[$];
        st_t         sq[$];
        int          cyc = 0;
        bit          prev_ld, active, pend, eo, er, c_bc;
        int          wr_start, wr_end, hold_end;
        logic [7:0]  c_ch;
        logic [15:0] c_thr, lc;
        logic [31:0] lr;
        st_t         exp_st, got_st;
        wr_t         w;

        task automatic sched(input int s);
            wr_start = s;
            wr_end   = s + (c_bc ? NCH - 1 : 0);
            hold_end = wr_end + HT;
            for (int i = 0; i <= wr_end - s; i++)
                wq.push_back('{cyc: s + i, addr: (c_bc ? 8'(i) : c_ch), data: c_thr});
        endtask

        // Reference: inputs of cycle cyc-1 decide the expected outputs of cycle cyc.
        always @(posedge clk) begin
            cyc++;
            if (!rst_n) begin
                prev_ld = 0; active = 0; pend = 0; eo = 0; er = 0; lc = '0;
                wq.delete();
                sq.push_back('0);
            end else begin
                lr = load_reg;
                if (active && pend && sync_in) begin
                    pend = 0;
                    sched(cyc);
                end
                if (lr[29]) begin eo = 0; er = 0; end
                if (lr[31] && !prev_ld) begin
                    if (active) eo = 1;
                    else if (!lr[30] && int'(lr[23:16]) >= NCH) er = 1;
                    else begin
                        active = 1;
                        c_bc = lr[30]; c_ch = lr[23:16]; c_thr = lr[15:0];
                        if (SA != 0) pend = 1;
                        else sched(cyc);
                    end
                end
                if (active && !pend && cyc > hold_end) begin
                    lc++;
                    active = 0;
                end
                sq.push_back({active, active && !pend && cyc >= wr_start, lc, eo, er});
                prev_ld = lr[31];
            end
        end

        always @(negedge clk) begin
            if (sq.size() > 0) begin
                exp_st = sq.pop_front();
                if (!rst_n) exp_st = '0;
                got_st = {bus.busy, bus.capture_hold, bus.load_count, bus.err_overrun, bus.err_range};
                vectors++;
                if (got_st !== exp_st) begin
                    miscompares++;
                    $display("FAIL status[%0d] cyc %0d: got busy=%0b hold=%0b cnt=%0d ovr=%0b rng=%0b, want busy=%0b hold=%0b cnt=%0d ovr=%0b rng=%0b",
                             g, cyc, got_st.busy, got_st.hold, got_st.lc, got_st.eo, got_st.er,
                             exp_st.busy, exp_st.hold, exp_st.lc, exp_st.eo, exp_st.er);
                end
            end
            if (rst_n) begin
                if (bus.thr_we) begin
                    vectors++;
                    if (wq.size() == 0 || wq[0].cyc != cyc) begin
                        miscompares++;
                        $display("FAIL write_timing[%0d] cyc %0d: got write addr=%0d, want no write here", g, cyc, bus.thr_addr);
                    end else begin
                        w = wq.pop_front();
                        if (bus.thr_addr !== w.addr || bus.thr_data !== w.data) begin
                            miscompares++;
                            $display("FAIL write_data[%0d] cyc %0d: got addr=%0d data=%h, want addr=%0d data=%h",
                                     g, cyc, bus.thr_addr, bus.thr_data, w.addr, w.data);
                        end
                    end
                end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL missing_write[%0d] cyc %0d: got no write, want addr=%0d at cyc %0d", g, cyc, wq[0].addr, wq[0].cyc);
                    void'(wq.pop_front());
                end
            end
        end
    end

    function automatic bit rnd_sync();
        return $urandom_range(0, 9) == 0;
    endfunction

    task automatic step(input logic [31:0] lr, input bit sy);
        @(posedge clk);
        #1;
        load_reg = lr;
        sync_in  = sy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'h0, rnd_sync());
    endtask

    initial begin
        logic [31:0] cmd;
        bit          found;

        repeat (4) step(32'h0, 1'b0);
        rst_n = 1'b1;

        // Single load; the sync-aligned instance sees its sync 10 cycles after the edge.
        step(32'h8005_01F4, 1'b0);
        repeat (9) step(32'h0, 1'b0);
        step(32'h0, 1'b1);
        repeat (10) step(32'h0, 1'b0);

        // Broadcast sweep.
        step(32'hC000_0064, 1'b0);
        idle(300);

        // Second load edge in the middle of a sweep.
        step(32'hC000_0064, 1'b0);
        idle(100);
        step(32'hC000_0064, 1'b0);
        idle(250);

        // Out-of-range single channel, clear, then set and clear in the same cycle.
        step(32'h80F0_1234, 1'b0);
        idle(12);
        step(32'h2000_0000, 1'b0);
        idle(12);
        step(32'hA0F0_0001, 1'b0);
        idle(12);
        step(32'h2000_0000, 1'b0);
        idle(12);

        for (int n = 0; n < 30; n++) begin
            cmd = {1'b1, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                   5'b0, 8'($urandom), 16'($urandom)};
            for (int w = 0; w < $urandom_range(1, 3); w++) step(cmd, rnd_sync());
            for (int w = 0; w < $urandom_range(1, 40); w++)
                step($urandom & 32'h5FFF_FFFF, rnd_sync());
        end
        idle(300);

        // Reset in the middle of a sweep, then a normal load.
        step(32'hC000_0064, 1'b0);
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk);
            #2;
            if (u[0].bus.thr_we && u[0].bus.thr_addr == 8'd100) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL sweep_reach_addr100: got not reached, want reached");
        end
        rst_n = 1'b0;
        #1;
        load_reg = 32'h0;
        vectors++;
        if ({u[0].bus.thr_we, u[0].bus.thr_addr, u[0].bus.thr_data, u[0].bus.capture_hold,
             u[0].bus.busy, u[0].bus.load_count, u[0].bus.err_overrun, u[0].bus.err_range} !== '0) begin
            miscompares++;
            $display("FAIL reset_immediate: got we=%0b addr=%0d hold=%0b busy=%0b cnt=%0d, want all 0",
                     u[0].bus.thr_we, u[0].bus.thr_addr, u[0].bus.capture_hold, u[0].bus.busy, u[0].bus.load_count);
        end
        repeat (2) step(32'h0, 1'b0);
        rst_n = 1'b1;
        step(32'h8005_01F4, 1'b0);
        idle(10);

        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            step(32'h0, rnd_sync());
            if (!u[0].bus.busy && !u[1].bus.busy) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL drain_timeout: got still busy, want idle");
        end
        idle(5);

        vectors++;
        if (u[0].wq.size() != 0) begin
            miscompares++;
            $display("FAIL pending_writes[0]: got %0d outstanding, want 0", u[0].wq.size());
        end
        vectors++;
        if (u[1].wq.size() != 0) begin
            miscompares++;
            $display("FAIL pending_writes[1]: got %0d outstanding, want 0", u[1].wq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
